// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   ctrl_state_e : controller FSM state encoding (also exported on ctrl_state)
//   pipe_ctrl_t  : bundle of write-enable and flush strobes for the five
//                  pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
package pipe_ctrl_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int PERF_CNT_W = 32;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_EXC      = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    // Free-running pipeline: everything advances, nothing flushed.
    localparam pipe_ctrl_t CTRL_RUN   = 9'b11111_0000;
    // Held in reset: nothing written, every stage loads a bubble.
    localparam pipe_ctrl_t CTRL_RESET = 9'b00000_1111;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare.
//   ex_mem_read : instruction in EX is a load
//   ex_rt       : load destination register
//   id_rs/id_rt : source registers of the instruction in ID
//   hazard      : ID must wait one cycle for the load result
// Writes to the zero register never create a dependency.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    output logic                 hazard
);

    always_comb begin
        hazard = ex_mem_read && (ex_rt != ZERO_REG) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Inputs : clk, reset (sync, active-high), ID source regs, EX load info,
//          branch/jump redirects, dmem handshake, exception request.
// Outputs: write enables and flush strobes for PC, IF/ID, ID/EX, EX/MEM,
//          MEM/WB; exception vector select/ack; bus error pulse on dmem
//          timeout; FSM state for debug; two performance counters.
// Build option: define PIPE_HAZARD_PERF_EN to build the stall/flush
// counters; otherwise stall_cycles and flush_events read as zero.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_IDX_W-1:0]  id_rs,
    input  logic [REG_IDX_W-1:0]  id_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_IDX_W-1:0]  ex_rt,
    input  logic                  ex_branch_taken,
    input  logic                  id_jump,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    input  logic                  exc_req,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  id_ex_we,
    output logic                  ex_mem_we,
    output logic                  mem_wb_we,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_flush,
    output logic                  exc_pc_sel,
    output logic                  exc_ack,
    output logic                  bus_err,
    output logic [1:0]            ctrl_state,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_events
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    ctrl_state_e      state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    pipe_ctrl_t       ctrl;
    logic             load_use;
    logic             mem_stall;
    logic             timeout;

    load_use_detect u_load_use (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hazard      (load_use)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        ctrl          = CTRL_RUN;
        state_next    = state;
        wait_cnt_next = wait_cnt;
        exc_pc_sel    = 1'b0;
        exc_ack       = 1'b0;
        bus_err       = 1'b0;
        mem_stall     = dmem_req && !dmem_ready;
        timeout       = (state == ST_MEM_WAIT) && mem_stall && (wait_cnt == WAIT_LAST);

        if (reset) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (exc_req || timeout) begin
                        // A timed-out access is turned into an exception entry;
                        // MEM/WB still retires the older instruction.
                        ctrl.if_id_flush  = 1'b1;
                        ctrl.id_ex_flush  = 1'b1;
                        ctrl.ex_mem_flush = 1'b1;
                        exc_pc_sel        = 1'b1;
                        exc_ack           = 1'b1;
                        bus_err           = timeout;
                        state_next        = ST_EXC;
                        wait_cnt_next     = '0;
                    end else if (mem_stall) begin
                        ctrl.pc_we        = 1'b0;
                        ctrl.if_id_we     = 1'b0;
                        ctrl.id_ex_we     = 1'b0;
                        ctrl.ex_mem_we    = 1'b0;
                        ctrl.mem_wb_flush = 1'b1;
                        state_next        = ST_MEM_WAIT;
                        wait_cnt_next     = (state == ST_RUN) ? CNT_W'(1)
                                                              : wait_cnt + CNT_W'(1);
                    end else if (state == ST_MEM_WAIT) begin
                        // Access completed: release the pipeline with default enables.
                        state_next    = ST_RUN;
                        wait_cnt_next = '0;
                    end else if (ex_branch_taken) begin
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        // Jump in ID stays held in IF/ID and redirects next cycle.
                        ctrl.pc_we       = 1'b0;
                        ctrl.if_id_we    = 1'b0;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (id_jump) begin
                        ctrl.if_id_flush = 1'b1;
                    end
                end
                ST_EXC: begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end
                default: begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end
            endcase
        end
    end

    assign pc_we        = ctrl.pc_we;
    assign if_id_we     = ctrl.if_id_we;
    assign id_ex_we     = ctrl.id_ex_we;
    assign ex_mem_we    = ctrl.ex_mem_we;
    assign mem_wb_we    = ctrl.mem_wb_we;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign ctrl_state   = state;

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_CNT_W-1:0] stall_q;
    logic [PERF_CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!ctrl.pc_we) begin
                stall_q <= stall_q + PERF_CNT_W'(1);
            end
            if (ctrl.if_id_flush || ctrl.id_ex_flush || ctrl.ex_mem_flush) begin
                flush_q <= flush_q + PERF_CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (MEM_TIMEOUT=16).
// Inputs are driven at the falling edge; combinational outputs are sampled
// 1ns later, i.e. they describe the cycle ending at the next rising edge.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_mem_read, ex_branch_taken, id_jump;
    logic        dmem_req, dmem_ready, exc_req;
    logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        exc_pc_sel, exc_ack, bus_err;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles, flush_events;

    int n_cmp = 0;
    int n_err = 0;

    // {pc, if_id, id_ex, ex_mem, mem_wb} write enables
    localparam logic [4:0] WE_ALL   = 5'b11111;
    localparam logic [4:0] WE_NONE  = 5'b00000;
    localparam logic [4:0] WE_LU    = 5'b00111;
    localparam logic [4:0] WE_MEM   = 5'b00001;
    // {if_id, id_ex, ex_mem, mem_wb} flushes
    localparam logic [3:0] FL_NONE  = 4'b0000;
    localparam logic [3:0] FL_ALL   = 4'b1111;
    localparam logic [3:0] FL_LU    = 4'b0100;
    localparam logic [3:0] FL_BR    = 4'b1100;
    localparam logic [3:0] FL_JMP   = 4'b1000;
    localparam logic [3:0] FL_MEM   = 4'b0001;
    localparam logic [3:0] FL_EXC   = 4'b1110;
    // {exc_pc_sel, exc_ack, bus_err}
    localparam logic [2:0] MS_NONE  = 3'b000;
    localparam logic [2:0] MS_EXC   = 3'b110;
    localparam logic [2:0] MS_TMO   = 3'b111;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .id_jump         (id_jump),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .exc_req         (exc_req),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .id_ex_we        (id_ex_we),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_we       (mem_wb_we),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
        .exc_pc_sel      (exc_pc_sel),
        .exc_ack         (exc_ack),
        .bus_err         (bus_err),
        .ctrl_state      (ctrl_state),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; id_jump = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0; exc_req = 1'b0;
    endtask

    // Sample the current cycle's outputs, then advance to the next falling edge.
    task automatic expect_cycle(input string tag, input logic [4:0] we, input logic [3:0] fl,
                                input logic [2:0] ms, input logic [1:0] st);
        #1;
        check_eq({tag, "/we"},    32'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}), 32'(we));
        check_eq({tag, "/flush"}, 32'({if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}), 32'(fl));
        check_eq({tag, "/exc"},   32'({exc_pc_sel, exc_ack, bus_err}), 32'(ms));
        check_eq({tag, "/state"}, 32'(ctrl_state), 32'(st));
        @(negedge clk);
    endtask

    task automatic check_perf(input string tag, input logic [31:0] stalls, input logic [31:0] flushes);
`ifdef PIPE_HAZARD_PERF_EN
        check_eq({tag, "/stall_cycles"}, stall_cycles, stalls);
        check_eq({tag, "/flush_events"}, flush_events, flushes);
`else
        check_eq({tag, "/stall_cycles"}, stall_cycles, 32'd0);
        check_eq({tag, "/flush_events"}, flush_events, 32'd0);
`endif
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        expect_cycle("reset", WE_NONE, FL_ALL, MS_NONE, 2'd0);
        reset = 1'b0;
        #1;
        check_perf("reset_perf", 32'd0, 32'd0);
        expect_cycle("idle", WE_ALL, FL_NONE, MS_NONE, 2'd0);

        // Load-use on rs, one cycle only
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        expect_cycle("lu_rs", WE_LU, FL_LU, MS_NONE, 2'd0);
        clear_inputs();
        expect_cycle("lu_after", WE_ALL, FL_NONE, MS_NONE, 2'd0);

        // Load into r0 never stalls
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        expect_cycle("lu_r0", WE_ALL, FL_NONE, MS_NONE, 2'd0);

        // Load-use on rt
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
        expect_cycle("lu_rt", WE_LU, FL_LU, MS_NONE, 2'd0);

        // Branch beats load-use and jump
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd0;
        ex_branch_taken = 1'b1; id_jump = 1'b1;
        expect_cycle("br_lu", WE_ALL, FL_BR, MS_NONE, 2'd0);

        // Load-use defers a concurrent jump; jump alone flushes IF/ID
        ex_branch_taken = 1'b0;
        expect_cycle("lu_jmp", WE_LU, FL_LU, MS_NONE, 2'd0);
        clear_inputs(); id_jump = 1'b1;
        expect_cycle("jmp", WE_ALL, FL_JMP, MS_NONE, 2'd0);
        // Counted so far: 3 stalls (lu_rs, lu_rt, lu_jmp); 5 flush cycles
        // (lu_rs, lu_rt, br_lu, lu_jmp, jmp).
        clear_inputs();
        #1;
        check_perf("perf_mix", 32'd3, 32'd5);

        // Dmem wait: 3 cycles then ready; a branch during the wait is outranked
        dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        expect_cycle("mw1", WE_MEM, FL_MEM, MS_NONE, 2'd0);
        ex_branch_taken = 1'b0;
        expect_cycle("mw2", WE_MEM, FL_MEM, MS_NONE, 2'd1);
        expect_cycle("mw3", WE_MEM, FL_MEM, MS_NONE, 2'd1);
        dmem_ready = 1'b1;
        expect_cycle("mw_rdy", WE_ALL, FL_NONE, MS_NONE, 2'd1);
        clear_inputs();
        expect_cycle("mw_done", WE_ALL, FL_NONE, MS_NONE, 2'd0);

        // Timeout: 16th consecutive wait cycle raises bus_err + exception entry
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k < MEM_TIMEOUT; k++) begin
            expect_cycle($sformatf("tmo_w%0d", k), WE_MEM, FL_MEM, MS_NONE, (k == 1) ? 2'd0 : 2'd1);
        end
        expect_cycle("tmo_hit", WE_ALL, FL_EXC, MS_TMO, 2'd1);
        expect_cycle("tmo_exc", WE_ALL, FL_NONE, MS_NONE, 2'd2);
        clear_inputs();
        expect_cycle("tmo_run", WE_ALL, FL_NONE, MS_NONE, 2'd0);

        // Ready arriving on the would-be timeout cycle wins
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k < MEM_TIMEOUT; k++) begin
            expect_cycle($sformatf("rdy_w%0d", k), WE_MEM, FL_MEM, MS_NONE, (k == 1) ? 2'd0 : 2'd1);
        end
        dmem_ready = 1'b1;
        expect_cycle("rdy_last", WE_ALL, FL_NONE, MS_NONE, 2'd1);
        clear_inputs();
        expect_cycle("rdy_run", WE_ALL, FL_NONE, MS_NONE, 2'd0);

        // Exception on the 2nd wait cycle; held request is re-accepted after EXC
        dmem_req = 1'b1; dmem_ready = 1'b0;
        expect_cycle("xw1", WE_MEM, FL_MEM, MS_NONE, 2'd0);
        exc_req = 1'b1;
        expect_cycle("xw_exc", WE_ALL, FL_EXC, MS_EXC, 2'd1);
        dmem_req = 1'b0;
        expect_cycle("xw_in_exc", WE_ALL, FL_NONE, MS_NONE, 2'd2);
        expect_cycle("xw_reacc", WE_ALL, FL_EXC, MS_EXC, 2'd0);
        clear_inputs();
        expect_cycle("xw_exc2", WE_ALL, FL_NONE, MS_NONE, 2'd2);
        expect_cycle("xw_run", WE_ALL, FL_NONE, MS_NONE, 2'd0);

        // Reset in the middle of a wait
        dmem_req = 1'b1; dmem_ready = 1'b0;
        expect_cycle("rw1", WE_MEM, FL_MEM, MS_NONE, 2'd0);
        expect_cycle("rw2", WE_MEM, FL_MEM, MS_NONE, 2'd1);
        reset = 1'b1;
        expect_cycle("rw_rst", WE_NONE, FL_ALL, MS_NONE, 2'd1);
        reset = 1'b0;
        clear_inputs();
        #1;
        check_perf("rw_perf", 32'd0, 32'd0);
        expect_cycle("rw_run", WE_ALL, FL_NONE, MS_NONE, 2'd0);

        // Two load-use stalls plus one branch
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        expect_cycle("p_lu1", WE_LU, FL_LU, MS_NONE, 2'd0);
        clear_inputs();
        expect_cycle("p_idle1", WE_ALL, FL_NONE, MS_NONE, 2'd0);
        ex_mem_read = 1'b1; ex_rt = 5'd12; id_rt = 5'd12;
        expect_cycle("p_lu2", WE_LU, FL_LU, MS_NONE, 2'd0);
        clear_inputs(); ex_branch_taken = 1'b1;
        expect_cycle("p_br", WE_ALL, FL_BR, MS_NONE, 2'd0);
        clear_inputs();
        #1;
        check_perf("perf_final", 32'd2, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
